// File: rtl/alu_issue_unit.sv
// ---------------------------------------------------------------------------
// alu_issue_unit
//
// Purpose:
//   Command front end and writeback stage for alu_machine. Accepts ALU
//   commands over a valid/ready handshake, reads operands from a small
//   register file, drives A/B/OP into the combinational ALU, captures
//   {Extra, Out} one cycle later and writes the result back to the
//   destination register on the following edge.
//
//   Sequence per command: IDLE (accept) -> ISSUE (ALU sampled) -> WB
//   (result strobe, register write) -> IDLE.
//
// Build option:
//   ALU_ISSUE_FWD_EN - when defined, a new command may also be accepted
//                      during WB. A source index that matches the WB
//                      destination takes the WB result directly instead of
//                      the not-yet-written register. The immediate is never
//                      forwarded. Undefined: accept only in IDLE and no
//                      forwarding path exists.
//
// Parameters:
//   NREGS  number of 4-bit registers (power of 2, >= 2)
//   IDX_W  register index width, log2(NREGS)
//
// Ports:
//   CLK          clock, rising edge
//   RST          asynchronous active-high reset
//   CMD_VALID    command present
//   CMD_READY    unit can accept a command (0 while RST is high)
//   CMD_OP       ALU opcode, passed through to OP
//   CMD_DST      destination register index
//   CMD_SRCA     source register index for A
//   CMD_SRCB     source register index for B (unused when CMD_IMM_SEL=1)
//   CMD_IMM_SEL  1 = B comes from CMD_IMM
//   CMD_IMM      immediate operand
//   A, B, OP     registered operands/opcode to the ALU
//   ALU_OUT      ALU result
//   ALU_EXTRA    ALU extra bit (carry etc.)
//   RES_VALID    one-cycle result strobe (high during WB)
//   RES_DATA     {Extra, Out} of the most recently completed command
//   RES_DST      destination of the most recently completed command
//   EXTRA_FLAG   Extra bit of the last written-back command
//   BUSY         unit is not in IDLE
//   RD_IDX       debug read index
//   RD_DATA      combinational read of reg[RD_IDX]
// ---------------------------------------------------------------------------
module alu_issue_unit #(
  parameter int NREGS = 4,
  parameter int IDX_W = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [IDX_W-1:0] CMD_DST,
  input  logic [IDX_W-1:0] CMD_SRCA,
  input  logic [IDX_W-1:0] CMD_SRCB,
  input  logic             CMD_IMM_SEL,
  input  logic [3:0]       CMD_IMM,
  output logic [3:0]       A,
  output logic [3:0]       B,
  output logic [1:0]       OP,
  input  logic [3:0]       ALU_OUT,
  input  logic             ALU_EXTRA,
  output logic             RES_VALID,
  output logic [4:0]       RES_DATA,
  output logic [IDX_W-1:0] RES_DST,
  output logic             EXTRA_FLAG,
  output logic             BUSY,
  input  logic [IDX_W-1:0] RD_IDX,
  output logic [3:0]       RD_DATA
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_cmd_ready;
  logic             w_accept;

  // Register file: asynchronously cleared, so it is built from flops
  // rather than block RAM.
  logic [3:0]       r_regs [NREGS];

  // Operand / opcode registers driving the ALU.
  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic [1:0]       r_op;
  logic [IDX_W-1:0] r_dst;

  // Captured ALU result and the destination it belongs to. The destination
  // is copied separately from r_dst so that RES_DST stays tied to the
  // result even when a new command is accepted during WB.
  logic [4:0]       r_res;
  logic [IDX_W-1:0] r_res_dst;
  logic             r_extra;

  logic [3:0]       w_opnd_a;
  logic [3:0]       w_opnd_b;
  logic [3:0]       w_reg_a;
  logic [3:0]       w_reg_b;
  logic             w_wb_write;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and handshake decode
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cmd_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Ready is gated by RST so nothing is offered while held in reset.
        w_cmd_ready = ~RST;
        if (CMD_VALID && w_cmd_ready) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_next = S_WB;
      end
      S_WB: begin
`ifdef ALU_ISSUE_FWD_EN
        w_cmd_ready = ~RST;
        if (CMD_VALID && w_cmd_ready) begin
          w_state_next = S_ISSUE;
        end else begin
          w_state_next = S_IDLE;
        end
`else
        w_state_next = S_IDLE;
`endif
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_accept   = CMD_VALID & w_cmd_ready;
  assign w_wb_write = (r_state == S_WB);

  // -------------------------------------------------------------------------
  // Operand selection
  // -------------------------------------------------------------------------
  assign w_reg_a = r_regs[CMD_SRCA];
  assign w_reg_b = r_regs[CMD_SRCB];

`ifdef ALU_ISSUE_FWD_EN
  // An accept during WB happens on the same edge as the register write, so
  // the register file still holds the old value; take the WB result instead.
  logic w_fwd_a;
  logic w_fwd_b;

  assign w_fwd_a  = w_wb_write && (CMD_SRCA == r_res_dst);
  assign w_fwd_b  = w_wb_write && (CMD_SRCB == r_res_dst);
  assign w_opnd_a = w_fwd_a ? r_res[3:0] : w_reg_a;
  assign w_opnd_b = CMD_IMM_SEL ? CMD_IMM :
                    (w_fwd_b ? r_res[3:0] : w_reg_b);
`else
  assign w_opnd_a = w_reg_a;
  assign w_opnd_b = CMD_IMM_SEL ? CMD_IMM : w_reg_b;
`endif

  // -------------------------------------------------------------------------
  // Operand registers: change only on accept, hold otherwise
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_a   <= 4'd0;
      r_b   <= 4'd0;
      r_op  <= 2'd0;
      r_dst <= '0;
    end else if (w_accept) begin
      r_a   <= w_opnd_a;
      r_b   <= w_opnd_b;
      r_op  <= CMD_OP;
      r_dst <= CMD_DST;
    end
  end

  // -------------------------------------------------------------------------
  // Result capture at the end of ISSUE; held until the next capture
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_res     <= 5'd0;
      r_res_dst <= '0;
    end else if (r_state == S_ISSUE) begin
      r_res     <= {ALU_EXTRA, ALU_OUT};
      r_res_dst <= r_dst;
    end
  end

  // Extra flag updates together with the register write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_extra <= 1'b0;
    end else if (w_wb_write) begin
      r_extra <= r_res[4];
    end
  end

  // -------------------------------------------------------------------------
  // Register file: one write port (WB), one entry per generated block.
  // Reset has priority, so a WB edge coinciding with reset leaves zeros.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_regs[gi] <= 4'd0;
        end else if (w_wb_write && (r_res_dst == IDX_W'(gi))) begin
          r_regs[gi] <= r_res[3:0];
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign CMD_READY  = w_cmd_ready;
  assign A          = r_a;
  assign B          = r_b;
  assign OP         = r_op;
  assign RES_VALID  = (r_state == S_WB);
  assign RES_DATA   = r_res;
  assign RES_DST    = r_res_dst;
  assign EXTRA_FLAG = r_extra;
  assign BUSY       = (r_state != S_IDLE);
  assign RD_DATA    = r_regs[RD_IDX];

endmodule
